// File: rtl/gumnut_ctrl.sv
// Gumnut control unit: a multi-cycle FSM that sequences instruction fetch, decode,
// execute, memory and writeback, and owns the PC, the Z/C flags and the return stack.
module gumnut_ctrl #(
  parameter int          STACK_DEPTH = 8,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  op_e,
  input  logic [2:0]  func_e,
  input  logic [11:0] addr_e,
  input  logic [7:0]  disp_e,
  input  logic        zero_e,
  input  logic        carry_e,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  output logic [11:0] inst_adr_o,
  input  logic        inst_ack_i,
  output logic        data_cyc_o,
  output logic        data_stb_o,
  output logic        data_we_o,
  input  logic        data_ack_i,
  output logic        port_cyc_o,
  output logic        port_stb_o,
  output logic        port_we_o,
  input  logic        port_ack_i,
  output logic        RegWrt_c,
  output logic        ClkEn_e,
  output logic [1:0]  RegMux_c,
  output logic        op2_c,
  output logic [3:0]  ALUOp_c,
  input  logic        wake_i,
  output logic        halt_o,
  output logic        stk_err_o
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W:0] C_DEPTH = (SP_W + 1)'(STACK_DEPTH);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  logic [2:0]      r_state;
  logic [11:0]     r_pc;
  logic            r_z;
  logic            r_c;
  logic [SP_W-1:0] r_sp;
  logic [SP_W:0]   r_cnt;
  logic            r_err;
  logic [11:0]     r_stack [STACK_DEPTH];

  // Zero or multi-hot opcodes decode to no class at all and fall through as NOPs.
  logic w_valid, w_alur, w_alui, w_shift, w_mem, w_br, w_jmp, w_misc;
  assign w_valid = (op_e != 7'd0) && ((op_e & (op_e - 7'd1)) == 7'd0);
  assign w_alur  = w_valid & op_e[0];
  assign w_alui  = w_valid & op_e[1];
  assign w_shift = w_valid & op_e[2];
  assign w_mem   = w_valid & op_e[3];
  assign w_br    = w_valid & op_e[4];
  assign w_jmp   = w_valid & op_e[5];
  assign w_misc  = w_valid & op_e[6];

  logic w_alu_any, w_mem_ok, w_is_port, w_is_load, w_bus_ack;
  assign w_alu_any = w_alur | w_alui | w_shift;
  assign w_mem_ok  = w_mem & ~func_e[2];
  assign w_is_port = func_e[1];
  assign w_is_load = ~func_e[0];
  assign w_bus_ack = w_is_port ? port_ack_i : data_ack_i;

  logic w_taken;
  always_comb begin
    case (func_e)
      3'd0:    w_taken = r_z;
      3'd1:    w_taken = ~r_z;
      3'd2:    w_taken = r_c;
      3'd3:    w_taken = ~r_c;
      default: w_taken = 1'b0;
    endcase
  end

  logic            w_push, w_pop;
  logic [SP_W-1:0] w_sp_dec;
  logic [11:0]     w_pc_br;
  assign w_push   = (r_state == S_EXECUTE) && w_jmp && (func_e == 3'd1);
  assign w_pop    = (r_state == S_EXECUTE) && w_misc && (func_e == 3'd0);
  assign w_sp_dec = r_sp - 1'b1;
  assign w_pc_br  = r_pc + {{4{disp_e[7]}}, disp_e};

  // Stack storage carries no reset; only the pointer and occupancy count do.
  always_ff @(posedge clk_i) begin
    if (w_push) r_stack[r_sp] <= r_pc;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (inst_ack_i) begin
            r_pc    <= r_pc + 12'd1;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXECUTE;
        S_EXECUTE: begin
          r_state <= S_FETCH;
          if (w_alu_any) r_state <= S_WRITEBACK;
          if (w_mem_ok)  r_state <= S_MEM;
          if (w_br && w_taken) r_pc <= w_pc_br;
          if (w_jmp && (func_e[2:1] == 2'b00)) r_pc <= addr_e;
          if (w_misc && (func_e == 3'd4 || func_e == 3'd5)) r_state <= S_HALT;
          if (w_push) begin
            r_sp <= r_sp + 1'b1;
            if (r_cnt == C_DEPTH) r_err <= 1'b1;
            else                  r_cnt <= r_cnt + 1'b1;
          end
          // A pop from an empty stack still returns whatever sits below the pointer.
          if (w_pop) begin
            r_sp <= w_sp_dec;
            r_pc <= r_stack[w_sp_dec];
            if (r_cnt == '0) r_err <= 1'b1;
            else             r_cnt <= r_cnt - 1'b1;
          end
        end
        S_MEM: begin
          if (w_bus_ack) r_state <= w_is_load ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: begin
          if (w_alu_any) begin
            r_z <= zero_e;
            r_c <= carry_e;
          end
          r_state <= S_FETCH;
        end
        S_HALT: begin
          if (wake_i) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  logic [3:0] w_alu_op;
  assign w_alu_op = w_shift ? {2'b10, func_e[1:0]} : {1'b0, func_e};

  // Outputs are gated by rst_i so a reset mid bus cycle drops strobes at once.
  always_comb begin
    inst_cyc_o = 1'b0;
    inst_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    port_cyc_o = 1'b0;
    port_stb_o = 1'b0;
    port_we_o  = 1'b0;
    RegWrt_c   = 1'b0;
    ClkEn_e    = 1'b0;
    RegMux_c   = 2'b00;
    op2_c      = 1'b1;
    ALUOp_c    = 4'b0000;
    halt_o     = 1'b0;
    if (rst_i) begin
      case (r_state)
        S_FETCH: begin
          inst_cyc_o = 1'b1;
          inst_stb_o = 1'b1;
        end
        S_EXECUTE: begin
          if (w_alu_any) begin
            ALUOp_c = w_alu_op;
            op2_c   = ~w_alui;
          end else if (w_mem) begin
            op2_c   = 1'b0;
          end
        end
        S_MEM: begin
          op2_c = 1'b0;
          if (w_is_port) begin
            port_cyc_o = 1'b1;
            port_stb_o = 1'b1;
            port_we_o  = ~w_is_load;
          end else begin
            data_cyc_o = 1'b1;
            data_stb_o = 1'b1;
            data_we_o  = ~w_is_load;
          end
        end
        S_WRITEBACK: begin
          RegWrt_c = 1'b1;
          ClkEn_e  = 1'b1;
          if (w_mem) begin
            RegMux_c = w_is_port ? 2'b10 : 2'b01;
          end else begin
            ALUOp_c = w_alu_op;
            op2_c   = ~w_alui;
          end
        end
        S_HALT:  halt_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign inst_adr_o = r_pc;
  assign stk_err_o  = r_err;

endmodule

// File: tb/tb_gumnut_ctrl.sv
// Directed testbench for gumnut_ctrl: walks ALU, memory, I/O, branch, jump/return,
// halt/wake and mid-cycle reset with hand-computed expectations.
module tb_gumnut_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  op_e;
  logic [2:0]  func_e;
  logic [11:0] addr_e;
  logic [7:0]  disp_e;
  logic        zero_e, carry_e;
  logic        inst_cyc_o, inst_stb_o, inst_ack_i;
  logic [11:0] inst_adr_o;
  logic        data_cyc_o, data_stb_o, data_we_o, data_ack_i;
  logic        port_cyc_o, port_stb_o, port_we_o, port_ack_i;
  logic        RegWrt_c, ClkEn_e, op2_c;
  logic [1:0]  RegMux_c;
  logic [3:0]  ALUOp_c;
  logic        wake_i, halt_o, stk_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_i = ~clk_i;

  gumnut_ctrl #(.STACK_DEPTH(8), .RESET_PC(12'h000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .op_e(op_e), .func_e(func_e), .addr_e(addr_e), .disp_e(disp_e),
    .zero_e(zero_e), .carry_e(carry_e),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
    .inst_ack_i(inst_ack_i),
    .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
    .data_ack_i(data_ack_i),
    .port_cyc_o(port_cyc_o), .port_stb_o(port_stb_o), .port_we_o(port_we_o),
    .port_ack_i(port_ack_i),
    .RegWrt_c(RegWrt_c), .ClkEn_e(ClkEn_e), .RegMux_c(RegMux_c),
    .op2_c(op2_c), .ALUOp_c(ALUOp_c),
    .wake_i(wake_i), .halt_o(halt_o), .stk_err_o(stk_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Present an instruction in FETCH with an immediate ack; returns in DECODE.
  task automatic fetch(input logic [6:0] op, input logic [2:0] f,
                       input logic [11:0] a, input logic [7:0] d);
    op_e = op; func_e = f; addr_e = a; disp_e = d;
    inst_ack_i = 1'b1;
    tick();
    inst_ack_i = 1'b0;
  endtask

  task automatic run_flow(input logic [6:0] op, input logic [2:0] f,
                          input logic [11:0] a, input logic [7:0] d);
    fetch(op, f, a, d);
    tick();
    tick();
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f,
                         input logic z, input logic c,
                         input logic [3:0] exp_aluop, input logic exp_op2);
    fetch(op, f, 12'h000, 8'h00);
    tick();
    #1;
    chk({tag, "_aluop"}, ALUOp_c, exp_aluop);
    chk({tag, "_op2"}, op2_c, exp_op2);
    tick();
    zero_e = z; carry_e = c;
    #1;
    chk({tag, "_wb_regwrt"}, RegWrt_c, 1'b1);
    chk({tag, "_wb_regmux"}, RegMux_c, 2'b00);
    tick();
  endtask

  logic [11:0] ret_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ret_exp[0] = 12'h171; ret_exp[1] = 12'h161; ret_exp[2] = 12'h151; ret_exp[3] = 12'h141;
    ret_exp[4] = 12'h131; ret_exp[5] = 12'h121; ret_exp[6] = 12'h111; ret_exp[7] = 12'h101;

    rst_i = 1'b0; op_e = '0; func_e = '0; addr_e = '0; disp_e = '0;
    zero_e = 1'b0; carry_e = 1'b0; inst_ack_i = 1'b0; data_ack_i = 1'b0;
    port_ack_i = 1'b0; wake_i = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_inst_stb", inst_stb_o, 1'b0);
    chk("rst_regwrt", RegWrt_c, 1'b0);
    chk("rst_op2", op2_c, 1'b1);
    chk("rst_aluop", ALUOp_c, 4'b0000);
    chk("rst_stk_err", stk_err_o, 1'b0);
    chk("rst_halt", halt_o, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("first_inst_stb", inst_stb_o, 1'b1);
    chk("first_inst_adr", inst_adr_o, 12'h000);

    // Multi-hot opcode is a NOP: EXECUTE goes straight back to FETCH.
    fetch(7'h03, 3'd0, 12'h000, 8'h00);
    tick();
    #1;
    chk("nop_exec_regwrt", RegWrt_c, 1'b0);
    tick();
    #1;
    chk("nop_back_fetch", inst_stb_o, 1'b1);
    chk("nop_adr", inst_adr_o, 12'h001);

    // ALU-reg add with a one-cycle-late instruction ack.
    op_e = 7'h01; func_e = 3'd0;
    #1;
    chk("add_fetch1_stb", inst_stb_o, 1'b1);
    tick();
    inst_ack_i = 1'b1;
    #1;
    chk("add_fetch2_stb", inst_stb_o, 1'b1);
    tick();
    inst_ack_i = 1'b0;
    #1;
    chk("add_decode_stb", inst_stb_o, 1'b0);
    chk("add_decode_regwrt", RegWrt_c, 1'b0);
    tick();
    #1;
    chk("add_exec_aluop", ALUOp_c, 4'b0000);
    chk("add_exec_op2", op2_c, 1'b1);
    chk("add_exec_regwrt", RegWrt_c, 1'b0);
    tick();
    zero_e = 1'b1; carry_e = 1'b0;
    #1;
    chk("add_wb_regwrt", RegWrt_c, 1'b1);
    chk("add_wb_clken", ClkEn_e, 1'b1);
    chk("add_wb_regmux", RegMux_c, 2'b00);
    tick();
    #1;
    chk("add_after_regwrt", RegWrt_c, 1'b0);
    chk("add_after_clken", ClkEn_e, 1'b0);
    chk("add_next_adr", inst_adr_o, 12'h002);

    run_alu("imm", 7'h02, 3'd3, 1'b0, 1'b1, 4'b0011, 1'b0);
    run_alu("shift", 7'h04, 3'd6, 1'b1, 1'b0, 4'b1010, 1'b1);

    // ldm at 0x004: three wait cycles (one with a stray port ack), then data ack.
    fetch(7'h08, 3'd0, 12'h000, 8'h00);
    tick();
    #1;
    chk("ldm_exec_aluop", ALUOp_c, 4'b0000);
    chk("ldm_exec_op2", op2_c, 1'b0);
    tick();
    port_ack_i = 1'b1;
    #1;
    chk("ldm_mem1_stb", data_stb_o, 1'b1);
    chk("ldm_mem1_we", data_we_o, 1'b0);
    chk("ldm_mem1_port_stb", port_stb_o, 1'b0);
    tick();
    port_ack_i = 1'b0;
    #1;
    chk("ldm_mem2_stb", data_stb_o, 1'b1);
    tick();
    #1;
    chk("ldm_mem3_stb", data_stb_o, 1'b1);
    tick();
    data_ack_i = 1'b1;
    #1;
    chk("ldm_mem4_stb", data_stb_o, 1'b1);
    tick();
    data_ack_i = 1'b0;
    zero_e = 1'b0; carry_e = 1'b1;
    #1;
    chk("ldm_wb_stb", data_stb_o, 1'b0);
    chk("ldm_wb_regmux", RegMux_c, 2'b01);
    chk("ldm_wb_regwrt", RegWrt_c, 1'b1);
    tick();
    #1;
    chk("ldm_next_adr", inst_adr_o, 12'h005);

    // out at 0x005: port write, straight back to FETCH.
    fetch(7'h08, 3'd3, 12'h000, 8'h00);
    tick();
    tick();
    #1;
    chk("out_port_stb", port_stb_o, 1'b1);
    chk("out_port_we", port_we_o, 1'b1);
    chk("out_data_stb", data_stb_o, 1'b0);
    port_ack_i = 1'b1;
    tick();
    port_ack_i = 1'b0;
    #1;
    chk("out_fetch_stb", inst_stb_o, 1'b1);
    chk("out_no_wb", RegWrt_c, 1'b0);
    chk("out_next_adr", inst_adr_o, 12'h006);

    // Branches. Z=1, C=0 survive from the shift (the ldm writeback must not touch them).
    run_flow(7'h20, 3'd0, 12'h010, 8'h00);
    #1;
    chk("jmp_adr", inst_adr_o, 12'h010);
    run_flow(7'h10, 3'd0, 12'h000, 8'hFC);
    #1;
    chk("bz_taken_adr", inst_adr_o, 12'h00D);
    run_alu("add_z0", 7'h01, 3'd0, 1'b0, 1'b0, 4'b0000, 1'b1);
    run_flow(7'h20, 3'd0, 12'h010, 8'h00);
    run_flow(7'h10, 3'd0, 12'h000, 8'hFC);
    #1;
    chk("bz_not_taken_adr", inst_adr_o, 12'h011);
    run_flow(7'h10, 3'd3, 12'h000, 8'h02);
    #1;
    chk("bnc_taken_adr", inst_adr_o, 12'h014);

    // Nine nested subroutine calls overflow an 8-entry stack on the ninth.
    for (int i = 0; i < 9; i++) begin
      run_flow(7'h20, 3'd1, 12'h100 + 12'(i * 16), 8'h00);
      #1;
      chk($sformatf("jsb%0d_adr", i), inst_adr_o, 12'h100 + 12'(i * 16));
      chk($sformatf("jsb%0d_err", i), stk_err_o, (i == 8) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      run_flow(7'h40, 3'd0, 12'h000, 8'h00);
      #1;
      chk($sformatf("ret%0d_adr", i), inst_adr_o, ret_exp[i]);
    end
    chk("stk_err_sticky", stk_err_o, 1'b1);

    // wait at 0x101 halts; wake resumes fetching at 0x102.
    run_flow(7'h40, 3'd4, 12'h000, 8'h00);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("halt%0d_halt", i), halt_o, 1'b1);
      chk($sformatf("halt%0d_strobes", i),
          {inst_stb_o, data_stb_o, port_stb_o}, 3'b000);
      tick();
    end
    wake_i = 1'b1;
    tick();
    wake_i = 1'b0;
    #1;
    chk("wake_inst_stb", inst_stb_o, 1'b1);
    chk("wake_adr", inst_adr_o, 12'h102);
    chk("wake_halt", halt_o, 1'b0);

    // Reset in the middle of a data cycle.
    fetch(7'h08, 3'd0, 12'h000, 8'h00);
    tick();
    tick();
    #1;
    chk("mrst_pre_stb", data_stb_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("mrst_data_stb", data_stb_o, 1'b0);
    chk("mrst_data_cyc", data_cyc_o, 1'b0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("mrst_inst_adr", inst_adr_o, 12'h000);
    chk("mrst_inst_stb", inst_stb_o, 1'b1);
    chk("mrst_stk_err", stk_err_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gumnut_ctrl.md
GUMNUT_CTRL -- requirements
Module: gumnut_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8, return-stack entries (power of 2).
REQ-002 SHALL have parameter RESET_PC, default 12'h000, fetch address after reset.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports op_e in 7, func_e in 3, addr_e in 12, disp_e in 8, zero_e in 1, carry_e in 1: decoded fields and flags from the datapath.
REQ-006 SHALL have ports inst_cyc_o out 1, inst_stb_o out 1, inst_adr_o out 12, inst_ack_i in 1: instruction bus.
REQ-007 SHALL have ports data_cyc_o out 1, data_stb_o out 1, data_we_o out 1, data_ack_i in 1: data memory bus.
REQ-008 SHALL have ports port_cyc_o out 1, port_stb_o out 1, port_we_o out 1, port_ack_i in 1: I/O bus.
REQ-009 SHALL have ports RegWrt_c out 1, ClkEn_e out 1, RegMux_c out 2, op2_c out 1, ALUOp_c out 4: datapath controls.
REQ-010 SHALL have ports wake_i in 1 (leave halt), halt_o out 1 (in HALT), stk_err_o out 1 (sticky stack over/underflow).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-012 SHALL classify op_e one-hot: bit0 ALU-reg, bit1 ALU-immed, bit2 shift, bit3 memory, bit4 branch, bit5 jump, bit6 misc; zero or multi-hot op_e is a NOP.
REQ-013 FETCH: inst_cyc_o=inst_stb_o=1, inst_adr_o=PC; hold until inst_ack_i, then DECODE with PC<=PC+1 (12-bit wrap, 12'hFFF->12'h000).
REQ-014 DECODE: one cycle, no bus activity, then EXECUTE.
REQ-015 EXECUTE, ALU-reg: ALUOp_c={1'b0,func_e}, op2_c=1, then WRITEBACK.
REQ-016 EXECUTE, ALU-immed: ALUOp_c={1'b0,func_e}, op2_c=0, then WRITEBACK.
REQ-017 EXECUTE, shift: ALUOp_c={2'b10,func_e[1:0]}, then WRITEBACK.
REQ-018 EXECUTE, memory: ALUOp_c=4'b0000, op2_c=0 (rs+offset address); func_e 0=ldm, 1=stm, 2=inp, 3=out, others NOP to FETCH; valid ops go to MEM.
REQ-019 MEM: ALUOp_c/op2_c held as in EXECUTE; ldm/stm assert data_cyc_o/data_stb_o, inp/out assert port_cyc_o/port_stb_o; we=1 for stm/out; hold until matching ack; loads go to WRITEBACK, stores to FETCH.
REQ-020 WRITEBACK: one cycle, ClkEn_e=1, RegWrt_c=1; RegMux_c=00 for ALU/shift, 01 for ldm, 10 for inp; next FETCH.
REQ-021 Controller Z/C flag registers SHALL load zero_e/carry_e in WRITEBACK of ALU/shift instructions only.
REQ-022 Branch (EXECUTE): func_e 0=bz, 1=bnz, 2=bc, 3=bnc against stored flags; taken: PC<=PC+sign_extend(disp_e) (PC already incremented); others NOP; next FETCH.
REQ-023 Jump (EXECUTE): func_e 0=jmp PC<=addr_e; 1=jsb push PC then PC<=addr_e; next FETCH.
REQ-024 Misc (EXECUTE): func_e 0=ret pops PC; 4=wait and 5=stby enter HALT; others NOP to FETCH.
REQ-025 HALT: halt_o=1, no bus strobes; wake_i=1 moves to FETCH next cycle.
REQ-026 Return stack SHALL be circular, pointer wraps; push when full overwrites oldest and sets stk_err_o; pop when empty returns stale entry and sets stk_err_o.
REQ-027 Outside the states named above, RegWrt_c, ClkEn_e and all cyc/stb/we SHALL be 0; RegMux_c=00, op2_c=1, ALUOp_c=0000.
REQ-028 An ack arriving in a state not requesting that bus SHALL be ignored.

Reset
REQ-029 rst_i=0 SHALL, asynchronously and at any point including mid bus cycle, force FETCH, PC=RESET_PC, flags=0, stack pointer=0, stk_err_o=0, all outputs to REQ-027 values.
REQ-030 First inst_stb_o SHALL assert in the first cycle after rst_i rises.

Verification
REQ-031 ALU-reg add, inst_ack_i one cycle late -> FETCH 2 cycles, RegWrt_c/ClkEn_e pulse exactly 1 cycle 3 cycles after ack, ALUOp_c=0000, op2_c=1.
REQ-032 ldm, data_ack_i after 3 wait cycles -> data_stb_o high 4 cycles, data_we_o=0, then WRITEBACK with RegMux_c=01.
REQ-033 bz taken at PC=0x010 with disp_e=8'hFC and Z=1 -> next inst_adr_o=0x00D; with Z=0 -> 0x011.
REQ-034 Nine nested jsb then nine ret with STACK_DEPTH=8 -> stk_err_o set on 9th push; first 8 rets return correct addresses in LIFO order.
REQ-035 wait -> halt_o=1, no strobes for 10 cycles; wake_i pulse -> inst_stb_o next cycle at following address.
REQ-036 rst_i low during MEM with data_stb_o high -> data_stb_o drops immediately, inst_adr_o=RESET_PC after release.
